// File: rtl/inhibit_sequencer.sv
// inhibit_sequencer
//   Sequenced active-low core reset plus CHANNELS independent, runtime-programmable
//   inhibit (stall) outputs. Each channel runs OFF, PERIODIC, ONESHOT or RANDOM (LFSR).
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   enable     in   global run; low pauses all channels
//   cfg_we     in   configuration write strobe
//   cfg_ch     in   target channel (writes to cfg_ch >= CHANNELS are ignored)
//   cfg_mode   in   0 OFF, 1 PERIODIC, 2 ONESHOT, 3 RANDOM
//   cfg_on     in   on length in cycles; low byte is the threshold in RANDOM mode
//   cfg_off    in   off length in cycles
//   core_rst_n out  sequenced active-low reset for downstream logic
//   inhibit    out  registered inhibit per channel
//   done       out  one-shot completion flag per channel
//
// CNT_W must be at least 8 (RANDOM mode compares against cfg_on[7:0]).
module inhibit_sequencer #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RESET_HOLD = 2,
    parameter logic [15:0] SEED       = 16'hACE1,
    localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_on,
    input  logic [CNT_W-1:0]    cfg_off,
    output logic                core_rst_n,
    output logic [CHANNELS-1:0] inhibit,
    output logic [CHANNELS-1:0] done
);

    localparam int unsigned HOLD_W = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [1:0] {
        ModeOff      = 2'd0,
        ModePeriodic = 2'd1,
        ModeOneshot  = 2'd2,
        ModeRandom   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StOn   = 2'd0,
        StOff  = 2'd1,
        StDone = 2'd2
    } phase_e;

    // Galois LFSR, taps 16'hB400, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // ------------------------------------------------------------------
    // Reset sequencing: core_rst_n rises on the (RESET_HOLD+1)th edge with rst low.
    // ------------------------------------------------------------------
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              core_rst_n_q, core_rst_n_d;

    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        core_rst_n_d = core_rst_n_q;
        if (!core_rst_n_q) begin
            if (hold_cnt_q == HOLD_W'(RESET_HOLD)) begin
                core_rst_n_d = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q   <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            hold_cnt_q   <= hold_cnt_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign core_rst_n = core_rst_n_q;

    logic run;
    assign run = core_rst_n_q & enable;

    // ------------------------------------------------------------------
    // Per-channel pattern generators
    // ------------------------------------------------------------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        mode_e            mode_q, mode_d;
        phase_e           phase_q, phase_d;
        logic [CNT_W-1:0] on_q, on_d;
        logic [CNT_W-1:0] off_q, off_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             inh_q, inh_d;
        logic             done_q, done_d;
        logic [15:0]      lfsr_q, lfsr_d;
        logic             wr;

        assign wr = cfg_we && (cfg_ch == CH_W'(c));

        always_comb begin
            mode_d  = mode_q;
            phase_d = phase_q;
            on_d    = on_q;
            off_d   = off_q;
            cnt_d   = cnt_q;
            inh_d   = inh_q;
            done_d  = done_q;
            // The LFSR free-runs on every run edge regardless of mode; only rst reseeds it.
            lfsr_d  = run ? lfsr_step(lfsr_q) : lfsr_q;

            if (wr) begin
                // A write restarts the channel and wins over any same-edge transition.
                mode_d  = mode_e'(cfg_mode);
                on_d    = cfg_on;
                off_d   = cfg_off;
                phase_d = StOn;
                cnt_d   = '0;
                inh_d   = 1'b0;
                done_d  = 1'b0;
            end else if (!run) begin
                inh_d = 1'b0;
            end else begin
                unique case (mode_q)
                    ModeOff: begin
                        inh_d = 1'b0;
                        cnt_d = '0;
                    end
                    ModePeriodic: begin
                        case (phase_q)
                            StOn: begin
                                if (on_q == '0) begin
                                    inh_d = 1'b0;
                                end else begin
                                    inh_d = 1'b1;
                                    if (cnt_q == on_q - CntOne) begin
                                        cnt_d = '0;
                                        // off == 0 means stay asserted continuously
                                        if (off_q != '0) begin
                                            phase_d = StOff;
                                        end
                                    end else begin
                                        cnt_d = cnt_q + CntOne;
                                    end
                                end
                            end
                            StOff: begin
                                inh_d = 1'b0;
                                if (cnt_q == off_q - CntOne) begin
                                    cnt_d   = '0;
                                    phase_d = StOn;
                                end else begin
                                    cnt_d = cnt_q + CntOne;
                                end
                            end
                            default: inh_d = 1'b0;
                        endcase
                    end
                    ModeOneshot: begin
                        case (phase_q)
                            StOn: begin
                                if (on_q == '0) begin
                                    inh_d   = 1'b0;
                                    done_d  = 1'b1;
                                    phase_d = StDone;
                                end else begin
                                    inh_d = 1'b1;
                                    if (cnt_q == on_q - CntOne) begin
                                        cnt_d   = '0;
                                        done_d  = 1'b1;
                                        phase_d = StDone;
                                    end else begin
                                        cnt_d = cnt_q + CntOne;
                                    end
                                end
                            end
                            default: inh_d = 1'b0;
                        endcase
                    end
                    ModeRandom: begin
                        inh_d = (lfsr_d[7:0] < on_q[7:0]);
                        cnt_d = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mode_q  <= ModeOff;
                phase_q <= StOn;
                on_q    <= '0;
                off_q   <= '0;
                cnt_q   <= '0;
                inh_q   <= 1'b0;
                done_q  <= 1'b0;
                lfsr_q  <= SEED ^ 16'(c + 1);
            end else begin
                mode_q  <= mode_d;
                phase_q <= phase_d;
                on_q    <= on_d;
                off_q   <= off_d;
                cnt_q   <= cnt_d;
                inh_q   <= inh_d;
                done_q  <= done_d;
                lfsr_q  <= lfsr_d;
            end
        end

        assign inhibit[c] = inh_q;
        assign done[c]    = done_q;
    end

endmodule
